poly_voice_synth: RTL and testbench

Polyphonic successor to the single-voice MIDI-to-DDS path: accepts decoded 3-byte MIDI events and allocates up to N_VOICES simultaneous notes. Voice stealing is oldest-first. On each sample tick the block time-multiplexes one phase accumulator update per voice and mixes the voice waveforms into one signed sample. It sits between the UART MIDI receiver and the I2S output / vocoder carrier input, and uses an external note-to-phase-increment lookup.

---
 rtl/poly_voice_synth_if.sv | 31 +++
 rtl/poly_voice_synth.sv | 182 ++++++++++++++++++
 tb/tb_poly_voice_synth.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/poly_voice_synth_if.sv
// Bus bundle for poly_voice_synth: MIDI event input, sample tick, external
// phase-increment lookup and mixed-sample output.
interface poly_voice_synth_if #(
   parameter int N_VOICES     = 8,
   parameter int PHASE_BITS   = 32,
   parameter int SAMPLE_WIDTH = 24
);
   // midi_valid_in, sample_tick_in and valid_out are single-cycle strobes with
   // no ready/backpressure; lut_incr_in must answer lut_note_out in the same cycle.
   logic                    midi_valid_in;
   logic [23:0]             midi_event_in;
   logic                    sample_tick_in;
   logic [1:0]              wave_type_in;
   logic [6:0]              lut_note_out;
   logic [PHASE_BITS-1:0]   lut_incr_in;
   logic [SAMPLE_WIDTH-1:0] sample_out;
   logic                    valid_out;
   logic                    busy_out;
   logic [N_VOICES-1:0]     active_out;
   logic [1:0]              dbg_state_out;

   modport master (
      output midi_valid_in, midi_event_in, sample_tick_in, wave_type_in, lut_incr_in,
      input  lut_note_out, sample_out, valid_out, busy_out, active_out, dbg_state_out
   );

   modport slave (
      input  midi_valid_in, midi_event_in, sample_tick_in, wave_type_in, lut_incr_in,
      output lut_note_out, sample_out, valid_out, busy_out, active_out, dbg_state_out
   );
endinterface

// File: rtl/poly_voice_synth.sv
// Polyphonic DDS: oldest-first voice allocation from MIDI events and a
// time-multiplexed per-voice phase update / mix pass on every sample tick.
module poly_voice_synth #(
   parameter int N_VOICES     = 8,
   parameter int PHASE_BITS   = 32,
   parameter int SAMPLE_WIDTH = 24
) (
   input logic               clk_in,
   input logic               n_rst_in,
   poly_voice_synth_if.slave bus
);
   localparam int IW    = $clog2(N_VOICES);
   localparam int S     = SAMPLE_WIDTH;
   localparam int ACC_W = S + IW;
   localparam logic signed [S-1:0] SQ_POS = {1'b0, {(S-1){1'b1}}};
   localparam logic signed [S-1:0] SQ_NEG = {1'b1, {(S-2){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, OUT = 2'd2} state_t;

   state_t                  state_q;
   logic [IW-1:0]           idx_q;
   logic signed [ACC_W-1:0] acc_q;
   logic [S-1:0]            sample_q;
   logic                    valid_q;

   logic [N_VOICES-1:0]     active_q, active_d;
   logic [6:0]              note_q  [N_VOICES];
   logic [6:0]              note_d  [N_VOICES];
   logic [3:0]              age_q   [N_VOICES];
   logic [3:0]              age_d   [N_VOICES];
   logic [PHASE_BITS-1:0]   phase_q [N_VOICES];
   logic [PHASE_BITS-1:0]   phase_d [N_VOICES];

   // Event decode is omni: the channel nibble and the note MSB are ignored.
   logic [3:0] ev_status;
   logic [6:0] ev_note;
   logic       ev_vel_nz;
   logic       note_on, note_off;
   logic       unused_ev;

   assign ev_status = bus.midi_event_in[23:20];
   assign ev_note   = bus.midi_event_in[14:8];
   assign ev_vel_nz = |bus.midi_event_in[7:0];
   assign unused_ev = ^{bus.midi_event_in[19:16], bus.midi_event_in[15]};
   assign note_on   = bus.midi_valid_in && (ev_status == 4'h9) && ev_vel_nz;
   assign note_off  = bus.midi_valid_in &&
                      ((ev_status == 4'h8) || ((ev_status == 4'h9) && !ev_vel_nz));

   logic          hit, free;
   logic [IW-1:0] hit_idx, free_idx, steal_idx, tgt;
   logic [3:0]    best_age;

   always_comb begin
      hit       = 1'b0;
      hit_idx   = '0;
      free      = 1'b0;
      free_idx  = '0;
      for (int v = N_VOICES - 1; v >= 0; v--) begin
         if (active_q[v] && (note_q[v] == ev_note)) begin
            hit     = 1'b1;
            hit_idx = IW'(v);
         end
         if (!active_q[v]) begin
            free     = 1'b1;
            free_idx = IW'(v);
         end
      end
      // Stealing only happens with every voice active, so ages need no gating.
      steal_idx = '0;
      best_age  = age_q[0];
      for (int v = 1; v < N_VOICES; v++) begin
         if (age_q[v] > best_age) begin
            best_age  = age_q[v];
            steal_idx = IW'(v);
         end
      end
      tgt = hit ? hit_idx : (free ? free_idx : steal_idx);
   end

   logic [PHASE_BITS-1:0]   scan_phase;
   logic [S:0]              p;
   logic [S-1:0]            tri_u;
   logic signed [S-1:0]     wave;
   logic signed [ACC_W-1:0] wave_ext;
   logic [S-1:0]            acc_mix;

   assign scan_phase = phase_q[idx_q] + bus.lut_incr_in;
   assign p          = scan_phase[PHASE_BITS-1 -: S+1];
   assign tri_u      = p[S] ? ~p[S-1:0] : p[S-1:0];
   assign wave_ext   = {{IW{wave[S-1]}}, wave};
   assign acc_mix    = S'(acc_q >>> IW);

   always_comb begin
      case (bus.wave_type_in)
         2'd0:    wave = {~p[S], p[S-1:1]};
         2'd1:    wave = p[S] ? SQ_NEG : SQ_POS;
         2'd2:    wave = {~tri_u[S-1], tri_u[S-2:0]};
         default: wave = '0;
      endcase
   end

   // The MIDI write is applied after the scan update so it wins on a shared voice.
   always_comb begin
      active_d = active_q;
      note_d   = note_q;
      age_d    = age_q;
      phase_d  = phase_q;
      if ((state_q == SCAN) && active_q[idx_q]) phase_d[idx_q] = scan_phase;
      if (note_on) begin
         for (int v = 0; v < N_VOICES; v++) begin
            if (active_q[v] && (IW'(v) != tgt) && (age_q[v] != 4'hF))
               age_d[v] = age_q[v] + 4'd1;
         end
         age_d[tgt] = 4'd0;
         if (!hit) begin
            active_d[tgt] = 1'b1;
            note_d[tgt]   = ev_note;
            phase_d[tgt]  = '0;
         end
      end else if (note_off) begin
         for (int v = 0; v < N_VOICES; v++) begin
            if (active_q[v] && (note_q[v] == ev_note)) active_d[v] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_in or negedge n_rst_in) begin
      if (!n_rst_in) begin
         active_q <= '0;
         for (int v = 0; v < N_VOICES; v++) begin
            note_q[v]  <= '0;
            age_q[v]   <= '0;
            phase_q[v] <= '0;
         end
      end else begin
         active_q <= active_d;
         note_q   <= note_d;
         age_q    <= age_d;
         phase_q  <= phase_d;
      end
   end

   always_ff @(posedge clk_in or negedge n_rst_in) begin
      if (!n_rst_in) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         acc_q    <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.sample_tick_in) begin
                  state_q <= SCAN;
                  idx_q   <= '0;
                  acc_q   <= '0;
               end
            end
            SCAN: begin
               if (active_q[idx_q]) acc_q <= acc_q + wave_ext;
               if (idx_q == IW'(N_VOICES - 1)) state_q <= OUT;
               else                            idx_q   <= idx_q + IW'(1);
            end
            OUT: begin
               sample_q <= acc_mix;
               valid_q  <= 1'b1;
               idx_q    <= '0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.lut_note_out  = note_q[idx_q];
   assign bus.sample_out    = sample_q;
   assign bus.valid_out     = valid_q;
   assign bus.busy_out      = (state_q != IDLE);
   assign bus.active_out    = active_q;
   assign bus.dbg_state_out = state_q;
endmodule

// File: tb/tb_poly_voice_synth.sv
// Bench for poly_voice_synth: directed vector table, multi-cycle corner
// sequences and randomized traffic against an arithmetic voice model.
module tb_poly_voice_synth;
   localparam int NV = 8;
   localparam int PB = 32;
   localparam int SW = 24;

   typedef struct {
      bit          rst;
      bit          send;
      logic [23:0] ev;
      bit [1:0]    wave;
      bit          pass;
      logic [7:0]  exp_act;
      bit          chk;
      logic [23:0] exp_smp;
   } vec_t;

   logic     clk_in   = 1'b0;
   logic     n_rst_in = 1'b0;
   bit       lut_mode = 1'b0;
   bit [1:0] cur_wave = 2'd0;
   int       n_vec    = 0;
   int       n_miss   = 0;
   logic [SW-1:0] exp_q[$];
   vec_t     vecs [29];

   bit        m_active [NV];
   bit [6:0]  m_note   [NV];
   int        m_age    [NV];
   bit [31:0] m_phase  [NV];

   poly_voice_synth_if #(.N_VOICES(NV), .PHASE_BITS(PB), .SAMPLE_WIDTH(SW)) bus ();

   poly_voice_synth #(.N_VOICES(NV), .PHASE_BITS(PB), .SAMPLE_WIDTH(SW)) dut (
      .clk_in   (clk_in),
      .n_rst_in (n_rst_in),
      .bus      (bus)
   );

   always #5 clk_in = ~clk_in;

   function automatic bit [31:0] lut_fn(bit mode, logic [6:0] note);
      return mode ? (32'(note) * 32'h0135_79BD + 32'h0F0F_0F0F) : 32'h1000_0000;
   endfunction

   assign bus.lut_incr_in  = lut_fn(lut_mode, bus.lut_note_out);
   assign bus.wave_type_in = cur_wave;

   // Reference model: waveform values from the top 25 phase bits as plain integers.
   function automatic int wave_of(bit [31:0] ph, bit [1:0] w);
      int pv, half, low, u;
      pv   = int'(ph >> 7);
      half = 1 << 24;
      case (w)
         2'd0: return pv / 2 - (1 << 23);
         2'd1: return (pv >= half) ? -((1 << 23) - 1) : ((1 << 23) - 1);
         2'd2: begin
            low = pv % half;
            u   = (pv >= half) ? (half - 1 - low) : low;
            return u - (1 << 23);
         end
         default: return 0;
      endcase
   endfunction

   function automatic void model_reset();
      for (int v = 0; v < NV; v++) begin
         m_active[v] = 1'b0;
         m_note[v]   = '0;
         m_age[v]    = 0;
         m_phase[v]  = '0;
      end
   endfunction

   function automatic void model_midi(logic [23:0] ev);
      bit [3:0] st;
      bit [6:0] n;
      bit [7:0] vel;
      int       tgt;
      st  = ev[23:20];
      n   = ev[14:8];
      vel = ev[7:0];
      if (st == 4'h9 && vel != 0) begin
         tgt = -1;
         for (int v = 0; v < NV; v++)
            if (tgt < 0 && m_active[v] && m_note[v] == n) tgt = v;
         if (tgt < 0) begin
            for (int v = 0; v < NV; v++)
               if (tgt < 0 && !m_active[v]) tgt = v;
            if (tgt < 0) begin
               tgt = 0;
               for (int v = 1; v < NV; v++)
                  if (m_age[v] > m_age[tgt]) tgt = v;
            end
            m_note[tgt]  = n;
            m_phase[tgt] = '0;
         end
         for (int v = 0; v < NV; v++)
            if (v != tgt && m_active[v] && m_age[v] < 15) m_age[v]++;
         m_active[tgt] = 1'b1;
         m_age[tgt]    = 0;
      end else if (st == 4'h8 || (st == 4'h9 && vel == 0)) begin
         for (int v = 0; v < NV; v++)
            if (m_active[v] && m_note[v] == n) m_active[v] = 1'b0;
      end
   endfunction

   function automatic logic [7:0] model_mask();
      logic [7:0] m;
      for (int v = 0; v < NV; v++) m[v] = m_active[v];
      return m;
   endfunction

   // slot -1: event lands with the tick; slot k: with voice k's scan slot.
   function automatic logic [SW-1:0] model_pass(int slot, logic [23:0] ev, bit [1:0] w);
      int acc, q;
      acc = 0;
      if (slot == -1) model_midi(ev);
      for (int v = 0; v < NV; v++) begin
         if (m_active[v]) begin
            m_phase[v] = m_phase[v] + lut_fn(lut_mode, m_note[v]);
            acc = acc + wave_of(m_phase[v], w);
         end
         if (v == slot) model_midi(ev);
      end
      q = (acc >= 0) ? (acc / 8) : -((-acc + 7) / 8);
      return SW'(q);
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic reset_dut();
      @(negedge clk_in);
      n_rst_in           = 1'b0;
      bus.midi_valid_in  = 1'b0;
      bus.sample_tick_in = 1'b0;
      repeat (2) @(negedge clk_in);
      n_rst_in = 1'b1;
      model_reset();
   endtask

   task automatic send_midi(input logic [23:0] ev);
      @(negedge clk_in);
      bus.midi_valid_in = 1'b1;
      bus.midi_event_in = ev;
      @(negedge clk_in);
      bus.midi_valid_in = 1'b0;
      model_midi(ev);
      check("active_after_event", bus.active_out, model_mask());
   endtask

   task automatic run_pass(input int slot, input logic [23:0] ev);
      int got     = 0;
      bit busy_ok = 1'b1;
      exp_q.push_back(model_pass(slot, ev, cur_wave));
      @(negedge clk_in);
      bus.sample_tick_in = 1'b1;
      if (slot == -1) begin
         bus.midi_valid_in = 1'b1;
         bus.midi_event_in = ev;
      end
      for (int n = 1; n <= NV + 10 && got == 0; n++) begin
         @(negedge clk_in);
         bus.sample_tick_in = 1'b0;
         bus.midi_valid_in  = 1'b0;
         if (bus.busy_out !== (n <= NV + 1)) busy_ok = 1'b0;
         if (bus.valid_out === 1'b1) got = n;
         if (n == slot + 1) begin
            bus.midi_valid_in = 1'b1;
            bus.midi_event_in = ev;
         end
      end
      bus.midi_valid_in = 1'b0;
      check("tick_to_valid_latency", got, NV + 2);
      check("busy_window", {31'd0, busy_ok}, 1);
      check("sample_vs_model", bus.sample_out, exp_q.pop_front());
      check("active_after_pass", bus.active_out, model_mask());
      @(negedge clk_in);
      check("valid_single_cycle", bus.valid_out, 0);
   endtask

   function automatic logic [23:0] rand_ev();
      int       r;
      bit [3:0] st;
      bit [7:0] vel;
      r   = int'($urandom_range(0, 5));
      st  = (r < 3) ? 4'h9 : ((r < 5) ? 4'h8 : 4'hB);
      vel = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 127));
      return {st, 4'($urandom_range(0, 15)), 1'b0, 7'(40 + $urandom_range(0, 11)), vel};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int nvalid;
      int ne;
      bus.midi_valid_in  = 1'b0;
      bus.midi_event_in  = '0;
      bus.sample_tick_in = 1'b0;

      vecs[0] = '{1'b0, 1'b1, 24'h903C64, 2'd0, 1'b0, 8'h01, 1'b0, 24'h0};
      vecs[1] = '{1'b0, 1'b0, 24'h0,      2'd0, 1'b1, 8'h01, 1'b1, 24'hF20000};
      vecs[2] = '{1'b0, 1'b0, 24'h0,      2'd0, 1'b1, 8'h01, 1'b1, 24'hF40000};
      vecs[3] = '{1'b0, 1'b0, 24'h0,      2'd0, 1'b1, 8'h01, 1'b1, 24'hF60000};
      vecs[4] = '{1'b0, 1'b0, 24'h0,      2'd0, 1'b1, 8'h01, 1'b1, 24'hF80000};
      for (int k = 0; k < 7; k++)
         vecs[5 + k] = '{1'b0, 1'b1, {8'h90, 8'(61 + k), 8'h64}, 2'd0, 1'b0,
                         8'((4 << k) - 1), 1'b0, 24'h0};
      vecs[12] = '{1'b0, 1'b1, 24'h904664, 2'd0, 1'b1, 8'hFF, 1'b1, 24'h900000};
      vecs[13] = '{1'b0, 1'b1, 24'h904164, 2'd0, 1'b1, 8'hFF, 1'b1, 24'hA00000};
      vecs[14] = '{1'b0, 1'b1, 24'h803E00, 2'd0, 1'b0, 8'hFB, 1'b0, 24'h0};
      vecs[15] = '{1'b0, 1'b1, 24'h953F00, 2'd0, 1'b0, 8'hF3, 1'b0, 24'h0};
      vecs[16] = '{1'b0, 1'b1, 24'h801000, 2'd0, 1'b0, 8'hF3, 1'b0, 24'h0};
      vecs[17] = '{1'b0, 1'b1, 24'hB04100, 2'd0, 1'b0, 8'hF3, 1'b0, 24'h0};
      vecs[18] = '{1'b1, 1'b1, 24'h90307F, 2'd0, 1'b0, 8'h01, 1'b0, 24'h0};
      for (int k = 0; k < 7; k++)
         vecs[19 + k] = '{1'b0, 1'b1, {8'h90, 8'(8'h31 + k), 8'h7F}, 2'd0, 1'b0,
                          8'((4 << k) - 1), 1'b0, 24'h0};
      vecs[26] = '{1'b0, 1'b0, 24'h0, 2'd1, 1'b1, 8'hFF, 1'b1, 24'h7FFFFF};
      vecs[27] = '{1'b0, 1'b0, 24'h0, 2'd3, 1'b1, 8'hFF, 1'b1, 24'h000000};
      vecs[28] = '{1'b0, 1'b0, 24'h0, 2'd2, 1'b1, 8'hFF, 1'b1, 24'hE00000};

      reset_dut();
      check("reset_sample_out", bus.sample_out, 0);
      check("reset_valid_out", bus.valid_out, 0);
      check("reset_busy_out", bus.busy_out, 0);
      check("reset_active_out", bus.active_out, 0);
      check("reset_lut_note_out", bus.lut_note_out, 0);

      for (int i = 0; i < 29; i++) begin
         if (vecs[i].rst) reset_dut();
         cur_wave = vecs[i].wave;
         if (vecs[i].send) send_midi(vecs[i].ev);
         if (vecs[i].pass) run_pass(-2, 24'h0);
         check($sformatf("vec%0d_active", i), bus.active_out, vecs[i].exp_act);
         if (vecs[i].chk) check($sformatf("vec%0d_sample", i), bus.sample_out, vecs[i].exp_smp);
      end

      // Extra ticks during the scan and during OUT must be dropped.
      reset_dut();
      cur_wave = 2'd0;
      send_midi(24'h903C64);
      send_midi(24'h903D64);
      exp_q.push_back(model_pass(-2, 24'h0, cur_wave));
      @(negedge clk_in);
      bus.sample_tick_in = 1'b1;
      nvalid = 0;
      for (int n = 1; n <= 2 * NV + 10; n++) begin
         @(negedge clk_in);
         bus.sample_tick_in = (n == 3) || (n == NV + 1);
         if (bus.valid_out === 1'b1) nvalid++;
      end
      check("dropped_tick_valid_count", nvalid, 1);
      check("dropped_tick_sample", bus.sample_out, exp_q.pop_front());

      // Steal of the oldest voice landing on its own scan slot.
      reset_dut();
      for (int k = 0; k < 8; k++) send_midi({8'h90, 8'(60 + k), 8'h64});
      run_pass(-2, 24'h0);
      run_pass(0, 24'h904664);
      check("steal_in_slot_sample", bus.sample_out, 24'hA00000);
      run_pass(-2, 24'h0);
      check("steal_in_slot_phase0", bus.sample_out, 24'hAC0000);
      run_pass(-1, 24'h904864);

      reset_dut();
      lut_mode = 1'b1;
      for (int it = 0; it < 40; it++) begin
         ne = int'($urandom_range(0, 3));
         for (int k = 0; k < ne; k++) send_midi(rand_ev());
         cur_wave = 2'($urandom_range(0, 3));
         run_pass(int'($urandom_range(0, 9)) - 2, rand_ev());
      end

      // Asynchronous reset in the middle of a scan.
      cur_wave = 2'd0;
      send_midi(24'h903C64);
      run_pass(-2, 24'h0);
      @(negedge clk_in);
      bus.sample_tick_in = 1'b1;
      repeat (3) @(negedge clk_in);
      bus.sample_tick_in = 1'b0;
      check("busy_before_reset", bus.busy_out, 1);
      n_rst_in = 1'b0;
      #1;
      check("midreset_sample_out", bus.sample_out, 0);
      check("midreset_valid_out", bus.valid_out, 0);
      check("midreset_busy_out", bus.busy_out, 0);
      check("midreset_active_out", bus.active_out, 0);
      check("midreset_lut_note_out", bus.lut_note_out, 0);
      @(negedge clk_in);
      n_rst_in = 1'b1;
      model_reset();
      nvalid = 0;
      for (int n = 0; n < NV + 6; n++) begin
         @(negedge clk_in);
         if (bus.valid_out === 1'b1 || bus.busy_out === 1'b1) nvalid++;
      end
      check("aborted_pass_no_valid", nvalid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
